// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared phase codes, state/class enums and default opcodes
package seq_pkg;

  localparam logic [2:0] PH_FETCH  = 3'b000;
  localparam logic [2:0] PH_DECODE = 3'b001;
  localparam logic [2:0] PH_EXT    = 3'b010;
  localparam logic [2:0] PH_SHORT  = 3'b011;
  localparam logic [2:0] PH_RESET  = 3'b100;
  localparam logic [2:0] PH_LONG0  = 3'b101;
  localparam logic [2:0] PH_HALT   = 3'b110;
  localparam logic [2:0] PH_LONGN  = 3'b111;

  // State encoding equals the legacy phase code, so the phase output is a pure decode.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXT    = 3'b010,
    ST_SHORT  = 3'b011,
    ST_RESET  = 3'b100,
    ST_LONG0  = 3'b101,
    ST_HALT   = 3'b110,
    ST_LONGN  = 3'b111
  } state_e;

  typedef enum logic [1:0] {
    CLS_SHORT = 2'd0,
    CLS_LONG  = 2'd1,
    CLS_EXT   = 2'd2,
    CLS_HALT  = 2'd3
  } op_class_e;

  localparam logic [7:0] DEF_EXT_OP  = 8'h84;
  localparam logic [7:0] DEF_HALT_OP = 8'hFF;
  localparam int         CNT_W       = 4;

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - instruction/control inputs and phase outputs of the sequencer
interface phase_sequencer_if #(
  parameter int IW = 16
);

  logic [IW-1:0] ins;
  logic          stall;
  logic          resume;
  logic [2:0]    phase;
  logic [3:0]    exec_idx;
  logic          instr_done;
  logic          halted;
  logic [IW-1:0] ir;

  modport master (
    output ins, stall, resume,
    input  phase, exec_idx, instr_done, halted, ir
  );

  modport slave (
    input  ins, stall, resume,
    output phase, exec_idx, instr_done, halted, ir
  );

endinterface

// File: rtl/phase_sequencer_op_class.sv
// rtl/phase_sequencer_op_class.sv - combinational opcode classifier (short/long/ext/halt)
module op_class
  import seq_pkg::*;
#(
  parameter int             OPW     = 8,
  parameter logic [OPW-1:0] EXT_OP  = DEF_EXT_OP,
  parameter logic [OPW-1:0] HALT_OP = DEF_HALT_OP
) (
  input  logic           msb,
  input  logic [OPW-1:0] opcode,
  output op_class_e      cls
);

  // HALT_OP always has its MSB set, so a short instruction can never alias it.
  always_comb begin
    cls = CLS_LONG;
    if (!msb) begin
      cls = CLS_SHORT;
    end else if (opcode == HALT_OP) begin
      cls = CLS_HALT;
    end else if (opcode == EXT_OP) begin
      cls = CLS_EXT;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - parametrised instruction-phase sequencer with stall, halt and ir latch
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int             IW        = 16,
  parameter int             OPW       = 8,
  parameter int             LONG_EXEC = 2,
  parameter logic [OPW-1:0] EXT_OP    = DEF_EXT_OP,
  parameter int             EXT_EXTRA = 1,
  parameter logic [OPW-1:0] HALT_OP   = DEF_HALT_OP
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXT    = ST_EXT;
  localparam logic [2:0] S_SHORT  = ST_SHORT;
  localparam logic [2:0] S_RESET  = ST_RESET;
  localparam logic [2:0] S_LONG0  = ST_LONG0;
  localparam logic [2:0] S_HALT   = ST_HALT;
  localparam logic [2:0] S_LONGN  = ST_LONGN;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_EXEC - 1);
  localparam logic [CNT_W-1:0] LONG_BASE = CNT_W'(LONG_EXEC);
  localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(EXT_EXTRA - 1);
  localparam bit               HAS_EXT   = (EXT_EXTRA > 0);

  if (LONG_EXEC < 1 || LONG_EXEC > 8) begin : g_bad_long_exec
    $error("phase_sequencer: LONG_EXEC must be in 1..8");
  end
  if (EXT_EXTRA < 0 || EXT_EXTRA > 7) begin : g_bad_ext_extra
    $error("phase_sequencer: EXT_EXTRA must be in 0..7");
  end
  if (!HALT_OP[OPW-1] || HALT_OP == EXT_OP) begin : g_bad_halt_op
    $error("phase_sequencer: HALT_OP needs MSB=1 and must differ from EXT_OP");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic             done;
  logic [2:0]       phase_w;
  logic [3:0]       exec_idx_w;
  op_class_e        ins_cls;
  op_class_e        ir_cls;

  op_class #(
    .OPW     (OPW),
    .EXT_OP  (EXT_OP),
    .HALT_OP (HALT_OP)
  ) u_ins_cls (
    .msb    (bus.ins[IW-1]),
    .opcode (bus.ins[IW-1 -: OPW]),
    .cls    (ins_cls)
  );

  // The EXT decision at the end of the long phases looks at the latched copy, not the live bus.
  op_class #(
    .OPW     (OPW),
    .EXT_OP  (EXT_OP),
    .HALT_OP (HALT_OP)
  ) u_ir_cls (
    .msb    (ir_q[IW-1]),
    .opcode (ir_q[IW-1 -: OPW]),
    .cls    (ir_cls)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!bus.stall) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!bus.stall) begin
          ir_d  = bus.ins;
          cnt_d = '0;
          case (ins_cls)
            CLS_SHORT: state_d = S_SHORT;
            CLS_HALT:  state_d = S_HALT;
            default:   state_d = S_LONG0;
          endcase
        end
      end
      S_SHORT: begin
        if (!bus.stall) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end
      end
      S_LONG0, S_LONGN: begin
        if (!bus.stall) begin
          if (cnt_q < LONG_LAST) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LONGN;
          end else if (HAS_EXT && ir_cls == CLS_EXT) begin
            cnt_d   = '0;
            state_d = S_EXT;
          end else begin
            cnt_d   = '0;
            state_d = S_FETCH;
            done    = 1'b1;
          end
        end
      end
      S_EXT: begin
        if (!bus.stall) begin
          if (cnt_q < EXT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = S_FETCH;
            done    = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (bus.resume) state_d = S_FETCH;
      end
      S_RESET: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    phase_w = PH_RESET;
    case (state_q)
      S_FETCH:  phase_w = PH_FETCH;
      S_DECODE: phase_w = PH_DECODE;
      S_SHORT:  phase_w = PH_SHORT;
      S_LONG0:  phase_w = PH_LONG0;
      S_LONGN:  phase_w = PH_LONGN;
      S_EXT:    phase_w = PH_EXT;
      S_HALT:   phase_w = PH_HALT;
      default:  phase_w = PH_RESET;
    endcase
  end

  // Extension phases continue numbering after the long phases.
  always_comb begin
    exec_idx_w = 4'd0;
    case (state_q)
      S_LONG0, S_LONGN: exec_idx_w = cnt_q;
      S_EXT:            exec_idx_w = LONG_BASE + cnt_q;
      default:          exec_idx_w = 4'd0;
    endcase
  end

  assign bus.phase      = phase_w;
  assign bus.exec_idx   = exec_idx_w;
  assign bus.instr_done = done;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.ir         = ir_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer, default and LONG_EXEC=4/EXT_EXTRA=3
module tb_phase_sequencer;
  import seq_pkg::*;

  typedef struct packed {
    logic [2:0]  ph;
    logic [3:0]  idx;
    logic        done;
    logic        hlt;
    logic [15:0] ir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [2];
  logic [15:0] ins_s    [2];
  logic        stall_s  [2];
  logic        resume_s [2];
  logic [15:0] ir_m     [2];
  int          le_c     [2];
  int          ee_c     [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  phase_sequencer_if #(.IW(16)) if0 ();
  phase_sequencer_if #(.IW(16)) if1 ();

  assign if0.ins    = ins_s[0];
  assign if0.stall  = stall_s[0];
  assign if0.resume = resume_s[0];
  assign if1.ins    = ins_s[1];
  assign if1.stall  = stall_s[1];
  assign if1.resume = resume_s[1];

  phase_sequencer dut0 (
    .clk   (clk),
    .reset (rst_s[0]),
    .bus   (if0)
  );

  phase_sequencer #(
    .LONG_EXEC (4),
    .EXT_EXTRA (3)
  ) dut1 (
    .clk   (clk),
    .reset (rst_s[1]),
    .bus   (if1)
  );

  function automatic void chk(input int c, input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL cfg%0d %s actual=%h required=%h at %0t", c, nm, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk(0, "phase",      {13'b0, if0.phase},      {13'b0, e.ph});
      chk(0, "exec_idx",   {12'b0, if0.exec_idx},   {12'b0, e.idx});
      chk(0, "instr_done", {15'b0, if0.instr_done}, {15'b0, e.done});
      chk(0, "halted",     {15'b0, if0.halted},     {15'b0, e.hlt});
      chk(0, "ir",         if0.ir,                  e.ir);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk(1, "phase",      {13'b0, if1.phase},      {13'b0, e.ph});
      chk(1, "exec_idx",   {12'b0, if1.exec_idx},   {12'b0, e.idx});
      chk(1, "instr_done", {15'b0, if1.instr_done}, {15'b0, e.done});
      chk(1, "halted",     {15'b0, if1.halted},     {15'b0, e.hlt});
      chk(1, "ir",         if1.ir,                  e.ir);
    end
  end

  // Drive one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic cyc(input int c, input logic [2:0] ph, input logic [3:0] idx, input logic stl,
                     input logic fin, input logic res, input logic rst, input logic [15:0] insv);
    exp_t e;
    rst_s[c]    = rst;
    ins_s[c]    = insv;
    stall_s[c]  = stl;
    resume_s[c] = res;
    e.ph   = ph;
    e.idx  = idx;
    e.done = fin & ~stl;
    e.hlt  = (ph == PH_HALT);
    e.ir   = ir_m[c];
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input int c, input logic rst);
    ir_m[c] = 16'h0000;
    cyc(c, PH_RESET, 4'd0, 1'($urandom), 1'b0, 1'($urandom), rst, 16'($urandom));
  endtask

  function automatic int pick_stalls(input int mode);
    if (mode == 1 && $urandom_range(0, 3) == 0) return $urandom_range(1, 3);
    return 0;
  endfunction

  task automatic phase_cyc(input int c, input logic [2:0] ph, input logic [3:0] idx,
                           input logic fin, input logic [15:0] insv, input int nst);
    for (int s = 0; s < nst; s++)
      cyc(c, ph, idx, 1'b1, fin, 1'($urandom), 1'b0, 16'($urandom));
    cyc(c, ph, idx, 1'b0, fin, 1'($urandom), 1'b0, insv);
  endtask

  // mode: 0 no stall, 1 random stalls, 2 exactly three stalls in the first long phase.
  task automatic run_ins(input int c, input logic [15:0] ins, input int mode, input bit abort, input int halt_len);
    int le = le_c[c];
    int ee = ee_c[c];
    bit ext;
    phase_cyc(c, PH_FETCH, 4'd0, 1'b0, 16'($urandom), pick_stalls(mode));
    phase_cyc(c, PH_DECODE, 4'd0, 1'b0, ins, pick_stalls(mode));
    ir_m[c] = ins;
    if (!ins[15]) begin
      phase_cyc(c, PH_SHORT, 4'd0, 1'b1, 16'($urandom), pick_stalls(mode));
    end else if (ins[15:8] == 8'hFF) begin
      for (int h = 0; h < halt_len; h++)
        cyc(c, PH_HALT, 4'd0, 1'($urandom), 1'b0, 1'b0, 1'b0, 16'($urandom));
      if (abort) begin
        cyc(c, PH_HALT, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom));
        reset_cycle(c, 1'b0);
      end else begin
        cyc(c, PH_HALT, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'($urandom));
      end
    end else begin
      ext = (ins[15:8] == 8'h84) && (ee > 0);
      for (int k = 0; k < le; k++)
        phase_cyc(c, (k == 0) ? PH_LONG0 : PH_LONGN, 4'(k), !ext && (k == le - 1),
                  16'($urandom), (mode == 2 && k == 0) ? 3 : pick_stalls(mode));
      if (ext) begin
        if (abort) begin
          cyc(c, PH_EXT, 4'(le), 1'b1, 1'b0, 1'($urandom), 1'b1, 16'($urandom));
          reset_cycle(c, 1'b0);
        end else begin
          for (int j = 0; j < ee; j++)
            phase_cyc(c, PH_EXT, 4'(le + j), j == ee - 1, 16'($urandom), pick_stalls(mode));
        end
      end
    end
  endtask

  task automatic run_cfg(input int c);
    logic [15:0] insv;
    bit ab;
    int r;
    @(posedge clk);
    #1;
    reset_cycle(c, 1'b1);
    reset_cycle(c, 1'b0);
    run_ins(c, 16'h1234, 0, 1'b0, 0);
    run_ins(c, 16'h8100, 0, 1'b0, 0);
    run_ins(c, 16'h8455, 0, 1'b0, 0);
    run_ins(c, 16'h8400, 0, 1'b0, 0);
    run_ins(c, 16'h8455, 2, 1'b0, 0);
    run_ins(c, 16'h8100, 2, 1'b0, 0);
    run_ins(c, 16'hFF00, 0, 1'b0, 10);
    run_ins(c, 16'h8455, 0, 1'b1, 0);
    run_ins(c, 16'hFF00, 0, 1'b1, 3);
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      ab = 1'b0;
      case (r)
        0, 1, 2: insv = {1'b0, 15'($urandom)};
        3, 4, 5: begin
          insv = 16'($urandom) | 16'h8000;
          if (insv[15:8] == 8'h84 || insv[15:8] == 8'hFF) insv[15:8] = 8'h90;
        end
        6, 7:    insv = {8'h84, 8'($urandom)};
        8:       insv = {8'hFF, 8'($urandom)};
        default: begin
          insv = $urandom_range(0, 1) ? {8'h84, 8'($urandom)} : {8'hFF, 8'($urandom)};
          ab   = 1'b1;
        end
      endcase
      run_ins(c, insv, 1, ab, $urandom_range(1, 5));
    end
  endtask

  initial begin
    le_c[0] = 2; ee_c[0] = 1;
    le_c[1] = 4; ee_c[1] = 3;
    for (int c = 0; c < 2; c++) begin
      rst_s[c]    = 1'b1;
      ins_s[c]    = 16'h0000;
      stall_s[c]  = 1'b0;
      resume_s[c] = 1'b0;
      ir_m[c]     = 16'h0000;
    end
    fork
      run_cfg(0);
      run_cfg(1);
    join
    @(negedge clk);
    @(negedge clk);
    chk(0, "drain", 16'(q0.size()), 16'd0);
    chk(1, "drain", 16'(q1.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
